fifo_rr_arb: RTL

FIFO_RR_ARB -- requirements
Module: fifo_rr_arb

---
 rtl/fifo_rr_arb.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fifo_rr_arb.sv
// Round-robin arbiter with burst hold, feeding a registered word into a shared FIFO write port.
// Define ARB_SRC_ID_EN to add the src_id output that tags each word with its requester index.
module fifo_rr_arb #(
    parameter int dw = 16,
    parameter int N  = 4,
    parameter int B  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_in,
    input  logic [N*dw-1:0]   d_in,
    output logic [N-1:0]      ack_in,
    output logic [dw-1:0]     d_out,
    output logic              req_out,
    input  logic              ack_out
`ifdef ARB_SRC_ID_EN
    ,
    output logic [$clog2(N)-1:0] src_id
`endif
);

    localparam int PW = $clog2(N);
    localparam int CW = $clog2(B + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t B_C     = cnt_t'(B);
    localparam ptr_t PTR_RST = ptr_t'(N - 1);

    logic [dw-1:0] d_out_q, d_out_d;
    logic          req_out_q, req_out_d;
    ptr_t          ptr_q, ptr_d;
    cnt_t          cnt_q, cnt_d;

    ptr_t winner;
    logic accept;
    logic grant;
    int   idx;

    assign accept = ~req_out_q | ack_out;
    assign grant  = ~rst & accept & (|req_in);

    // cnt == 0 only right after reset: no burst is in progress, so the search
    // starts past ptr = N-1 and the first grant lands on requester 0.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        winner = ptr_q;
        idx    = 0;
        if (req_in[ptr_q] && cnt_q != '0 && cnt_q < B_C) begin
            winner = ptr_q;
        end else begin
            // Descending loop: the nearest requester after ptr is written last and wins.
            for (int k = N; k >= 1; k--) begin
                idx = int'(ptr_q) + k;
                if (idx >= N) idx = idx - N;
                if (req_in[idx]) winner = ptr_t'(idx);
            end
        end
    end

    always_comb begin
        ack_in = '0;
        if (grant) ack_in[winner] = 1'b1;
    end

    always_comb begin
        d_out_d   = d_out_q;
        req_out_d = req_out_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        if (grant) begin
            d_out_d   = d_in[int'(winner)*dw +: dw];
            req_out_d = 1'b1;
            ptr_d     = winner;
            if (winner == ptr_q) begin
                cnt_d = (cnt_q == B_C) ? cnt_q : cnt_q + 1'b1;
            end else begin
                cnt_d = cnt_t'(1);
            end
        end else if (accept) begin
            req_out_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            d_out_q   <= '0;
            req_out_q <= 1'b0;
            ptr_q     <= PTR_RST;
            cnt_q     <= '0;
        end else begin
            d_out_q   <= d_out_d;
            req_out_q <= req_out_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign d_out   = d_out_q;
    assign req_out = req_out_q;

`ifdef ARB_SRC_ID_EN
    ptr_t src_id_q, src_id_d;

    always_comb begin
        src_id_d = src_id_q;
        if (grant) src_id_d = winner;
    end

    always_ff @(posedge clk) begin
        if (rst) src_id_q <= '0;
        else     src_id_q <= src_id_d;
    end

    assign src_id = src_id_q;
`else
    // Without the source tag the winner index only steers data and the pointer.
`endif

endmodule
